// File: rtl/reflow_source_pipe_pkg.sv
// -----------------------------------------------------------------------------
// reflow_source_pipe_pkg
//   Shared constants, slot record type and the forwarding-hit helper used by
//   the reflow source pipeline (EX/MEM and MEM/WB in-flight write tracking).
//   Optional build macro used by the importing files: REFLOW_STATS_EN.
// -----------------------------------------------------------------------------
package reflow_source_pipe_pkg;

   localparam int DW = 32;
   localparam int RW = 5;

   localparam logic [RW-1:0] REG_ZERO = 5'd0;

   // One in-flight register write. The load flag only has meaning in slot 1;
   // by the time a write reaches slot 2 its data is final.
   typedef struct packed {
      logic          v;
      logic          wen;
      logic [RW-1:0] wreg;
      logic [DW-1:0] data;
      logic          load;
   } reflow_slot_t;

   // A consumer source hits a forwarding port when the port is enabled, the
   // consumer really reads that source, and the register indices agree.
   function automatic logic reflow_hit(input logic          en,
                                       input logic [RW-1:0] req,
                                       input logic [RW-1:0] src,
                                       input logic          use_src);
      return en & use_src & (req == src);
   endfunction

endpackage

// File: rtl/reflow_source_pipe_slot.sv
// -----------------------------------------------------------------------------
// reflow_slot
//   One in-flight write slot register with hold and bubble controls.
//   Update priority on each rising edge: rst, hold, bubble, load.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears all fields)
//   hold             keep current contents
//   bubble           replace contents with an empty (invalid) slot
//   d_v .. d_load    next slot contents when neither hold nor bubble
//   q_v .. q_load    current slot contents
// -----------------------------------------------------------------------------
module reflow_slot
   import reflow_source_pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hold,
   input  logic          bubble,
   input  logic          d_v,
   input  logic          d_wen,
   input  logic [RW-1:0] d_wreg,
   input  logic [DW-1:0] d_data,
   input  logic          d_load,
   output logic          q_v,
   output logic          q_wen,
   output logic [RW-1:0] q_wreg,
   output logic [DW-1:0] q_data,
   output logic          q_load
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_v    <= 1'b0;
         q_wen  <= 1'b0;
         q_wreg <= '0;
         q_data <= '0;
         q_load <= 1'b0;
      end else if (!hold) begin
         if (bubble) begin
            q_v    <= 1'b0;
            q_wen  <= 1'b0;
            q_wreg <= '0;
            q_data <= '0;
            q_load <= 1'b0;
         end else begin
            q_v    <= d_v;
            q_wen  <= d_wen;
            q_wreg <= d_wreg;
            q_data <= d_data;
            q_load <= d_load;
         end
      end
   end

endmodule

// File: rtl/reflow_source_pipe.sv
// -----------------------------------------------------------------------------
// reflow_source_pipe
//   Tracks the register writes in flight in EX/MEM (slot 1) and MEM/WB
//   (slot 2) and drives the two source ports of the downstream operand
//   forwarding mux. Raises load_use_stall when the newest write is a load
//   a consumer needs before its data exists.
// Build option:
//   REFLOW_STATS_EN  adds saturating stat_stall_cnt / stat_fwd_cnt outputs.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid/wen/wreg/wdata/is_load   instruction leaving execute
//   mem_rdata                   load data for the instruction in slot 1
//   use_rs/use_rt, src_rs/src_rt      consumer source usage and indices
//   stall_in                    global freeze
//   flush                       squash the instruction entering slot 1
//   reflow_*_1                  newest forwarding source (slot 1)
//   reflow_*_2                  older forwarding source (slot 2)
//   load_use_stall              hold the consumer and everything upstream
// -----------------------------------------------------------------------------
module reflow_source_pipe
   import reflow_source_pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_valid,
   input  logic          ex_wen,
   input  logic [RW-1:0] ex_wreg,
   input  logic [DW-1:0] ex_wdata,
   input  logic          ex_is_load,
   input  logic [DW-1:0] mem_rdata,
   input  logic          use_rs,
   input  logic          use_rt,
   input  logic [RW-1:0] src_rs,
   input  logic [RW-1:0] src_rt,
   input  logic          stall_in,
   input  logic          flush,
   output logic          reflow_en_1,
   output logic [RW-1:0] reflow_req_1,
   output logic [DW-1:0] reflow_data_1,
   output logic          reflow_en_2,
   output logic [RW-1:0] reflow_req_2,
   output logic [DW-1:0] reflow_data_2,
   output logic          load_use_stall
`ifdef REFLOW_STATS_EN
   ,
   output logic [31:0]   stat_stall_cnt,
   output logic [31:0]   stat_fwd_cnt
`endif
);

   logic          v_p1, wen_p1, load_p1;
   logic [RW-1:0] wreg_p1;
   logic [DW-1:0] data_p1;

   logic          v_p2, wen_p2;
   logic [RW-1:0] wreg_p2;
   logic [DW-1:0] data_p2;
   logic          unused_load_p2;

   logic [DW-1:0] data_to_p2;

   // ---- EX -> slot 1 (EX/MEM) ----
   // A flush or a load-use hazard inserts a bubble; stall_in overrides both so
   // nothing moves while frozen.
   reflow_slot #(.DW(DW), .RW(RW)) u_slot_p1 (
      .clk    (clk),
      .rst    (rst),
      .hold   (stall_in),
      .bubble (flush | load_use_stall),
      .d_v    (ex_valid),
      .d_wen  (ex_wen),
      .d_wreg (ex_wreg),
      .d_data (ex_wdata),
      .d_load (ex_is_load),
      .q_v    (v_p1),
      .q_wen  (wen_p1),
      .q_wreg (wreg_p1),
      .q_data (data_p1),
      .q_load (load_p1)
   );

   // ---- slot 1 -> slot 2 (MEM/WB) ----
   // A load picks up its memory data on the way out of slot 1, so slot 2 never
   // carries a pending load.
   assign data_to_p2 = load_p1 ? mem_rdata : data_p1;

   reflow_slot #(.DW(DW), .RW(RW)) u_slot_p2 (
      .clk    (clk),
      .rst    (rst),
      .hold   (stall_in),
      .bubble (1'b0),
      .d_v    (v_p1),
      .d_wen  (wen_p1),
      .d_wreg (wreg_p1),
      .d_data (data_to_p2),
      .d_load (1'b0),
      .q_v    (v_p2),
      .q_wen  (wen_p2),
      .q_wreg (wreg_p2),
      .q_data (data_p2),
      .q_load (unused_load_p2)
   );

   // ---- forwarding ports and hazard detect ----
   // Slot 1 never forwards a load: its value is the address-phase ALU result.
   // Both ports may name the same register; the mux downstream prefers port 1.
   assign reflow_en_1   = v_p1 & wen_p1 & ~load_p1 & (wreg_p1 != REG_ZERO);
   assign reflow_req_1  = wreg_p1;
   assign reflow_data_1 = data_p1;

   assign reflow_en_2   = v_p2 & wen_p2 & (wreg_p2 != REG_ZERO);
   assign reflow_req_2  = wreg_p2;
   assign reflow_data_2 = data_p2;

   // A matching slot-2 entry does not cancel the stall: it is older than the
   // load and therefore stale.
   assign load_use_stall = v_p1 & wen_p1 & load_p1 & (wreg_p1 != REG_ZERO) &
                           (reflow_hit(1'b1, wreg_p1, src_rs, use_rs) |
                            reflow_hit(1'b1, wreg_p1, src_rt, use_rt));

`ifdef REFLOW_STATS_EN
   logic fwd_hit;

   assign fwd_hit = reflow_hit(reflow_en_1, reflow_req_1, src_rs, use_rs) |
                    reflow_hit(reflow_en_1, reflow_req_1, src_rt, use_rt) |
                    reflow_hit(reflow_en_2, reflow_req_2, src_rs, use_rs) |
                    reflow_hit(reflow_en_2, reflow_req_2, src_rt, use_rt);

   // Counters saturate rather than wrap so a long run never reads as short.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cnt <= '0;
         stat_fwd_cnt   <= '0;
      end else if (!stall_in) begin
         if (load_use_stall && (stat_stall_cnt != 32'hFFFF_FFFF))
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         if (fwd_hit && (stat_fwd_cnt != 32'hFFFF_FFFF))
            stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      end
   end
`endif

endmodule
